// File: rtl/calendar_pkg.sv
// Shared types and constants for the calendar day-of-year sequencer.
// Days are held as two BCD digits; there is never a binary copy of the day.
package calendar_pkg;

    typedef enum logic [1:0] {
        RUN,
        SET,
        EXIT
    } state_t;

    typedef logic [3:0] bcd_t;

    typedef struct packed {
        bcd_t tens;
        bcd_t units;
    } day_t;

    localparam day_t DAY_FIRST = 8'h01;
    localparam day_t DAY_59    = 8'h59;

    // Only ever called on elaboration-time constants to build the wrap limits.
    function automatic day_t bcd_of(input int unsigned n);
        day_t r;
        r.tens  = 4'(n / 10);
        r.units = 4'(n % 10);
        return r;
    endfunction

endpackage

// File: rtl/bcd_day_counter.sv
// Two-digit BCD day counter with load, increment and decrement.
// Both directions wrap against a limit that may change from cycle to cycle.
module bcd_day_counter
    import calendar_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic load,
    input  day_t load_val,
    input  logic inc,
    input  logic dec,
    input  day_t last,
    output day_t day,
    output logic wrapped
);

    day_t day_q;
    day_t day_d;

    always_comb begin
        day_d   = day_q;
        wrapped = 1'b0;
        if (load) begin
            day_d = load_val;
        end else if (inc) begin
            // BCD ordering matches numeric ordering, so a plain compare is safe.
            if (day_q >= last) begin
                day_d   = DAY_FIRST;
                wrapped = 1'b1;
            end else if (day_q.units == 4'd9) begin
                day_d.tens  = day_q.tens + 4'd1;
                day_d.units = 4'd0;
            end else begin
                day_d.units = day_q.units + 4'd1;
            end
        end else if (dec) begin
            if (day_q <= DAY_FIRST) begin
                day_d   = last;
                wrapped = 1'b1;
            end else if (day_q.units == 4'd0) begin
                day_d.tens  = day_q.tens - 4'd1;
                day_d.units = 4'd9;
            end else begin
                day_d.units = day_q.units - 4'd1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            day_q <= DAY_FIRST;
        end else begin
            day_q <= day_d;
        end
    end

    assign day = day_q;

endmodule

// File: rtl/calendar_ctrl.sv
// Day-of-year sequencer: advances on day ticks, wraps at year end, and offers
// a button-driven set mode with auto-repeat and a delayed change strobe.
module calendar_ctrl
    import calendar_pkg::*;
#(
    parameter int LAST_DAY   = 59,
    parameter int REPEAT_CYC = 8,
    parameter int CNT_W      = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       day_tick,
    input  logic       SW9,
    input  logic       set_en,
    input  logic       set_up,
    input  logic       set_dn,
    output logic [3:0] c10,
    output logic [3:0] c1,
    output logic       cal_step,
    output logic       year_wrap,
    output logic       setting
);

    localparam day_t LAST_NORMAL = bcd_of(LAST_DAY);
    localparam day_t LAST_LEAP   = bcd_of(LAST_DAY + 1);
    localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(REPEAT_CYC - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             set_up_q, set_dn_q;
    logic             pend_q, pend_d;
    logic             cal_step_q, cal_step_d;
    logic             year_wrap_q, year_wrap_d;

    day_t last;
    day_t day;
    logic inc, dec, load, wrapped;
    logic up_edge, dn_edge;

    assign last    = SW9 ? LAST_LEAP : LAST_NORMAL;
    assign up_edge = set_up & ~set_up_q;
    assign dn_edge = set_dn & ~set_dn_q;

    bcd_day_counter u_day (
        .clock    (clock),
        .reset    (reset),
        .load     (load),
        .load_val (last),
        .inc      (inc),
        .dec      (dec),
        .last     (last),
        .day      (day),
        .wrapped  (wrapped)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = '0;
        inc         = 1'b0;
        dec         = 1'b0;
        load        = 1'b0;
        year_wrap_d = 1'b0;
        case (state_q)
            RUN: begin
                // A tick arriving with set_en is still applied before entering SET.
                inc         = day_tick;
                year_wrap_d = day_tick & wrapped;
                if (set_en) state_d = SET;
            end
            SET: begin
                if (set_up && set_dn) begin
                    cnt_d = '0;
                end else if (up_edge || dn_edge) begin
                    inc = set_up;
                    dec = set_dn;
                end else if (set_up || set_dn) begin
                    if (cnt_q == CNT_TOP) begin
                        inc = set_up;
                        dec = set_dn;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                if (!set_en) state_d = EXIT;
            end
            EXIT: begin
                // The leap switch may have dropped while the day sat on the leap day.
                load    = (day > last);
                state_d = RUN;
            end
            default: state_d = RUN;
        endcase
        pend_d     = inc | dec | load;
        cal_step_d = pend_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= RUN;
            cnt_q       <= '0;
            set_up_q    <= 1'b0;
            set_dn_q    <= 1'b0;
            pend_q      <= 1'b0;
            cal_step_q  <= 1'b0;
            year_wrap_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            set_up_q    <= set_up;
            set_dn_q    <= set_dn;
            pend_q      <= pend_d;
            cal_step_q  <= cal_step_d;
            year_wrap_q <= year_wrap_d;
        end
    end

    assign c10       = day.tens;
    assign c1        = day.units;
    assign cal_step  = cal_step_q;
    assign year_wrap = year_wrap_q;
    assign setting   = (state_q == SET);

endmodule
